// File: rtl/return_address_stack.sv
// Return address stack for call/return prediction: circular buffer with
// overwrite-on-full, same-cycle replace backup, and flush rollback.
module return_address_stack #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RAS_push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  RAS_pop,
  input  logic                  RAS_rollback_pop_id,
  input  logic                  RAS_rollback_push_id,
  input  logic                  RAS_rollback_push_ex,
  input  logic                  WR_ra_track_en,
  input  logic [4:0]            WR_ra_track_data,
  output logic [ADDR_WIDTH-1:0] RAS_top,
  output logic                  RAS_top_valid,
  output logic [4:0]            RAS_ra_track,
  output logic                  RAS_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] entry [DEPTH];
  logic [ADDR_WIDTH-1:0] bk;
  logic                  bk_valid, bk_valid_next;
  logic [PTR_W-1:0]      wp, wp_next, wp_m1;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [4:0]            ra_track;

  logic rollback, do_push, do_pop, do_replace, restore;
  int   delta, cnt_rb;

  assign wp_m1      = wp - PTR_W'(1);
  assign rollback   = RAS_rollback_pop_id | RAS_rollback_push_id | RAS_rollback_push_ex;
  assign do_push    = RAS_push & ~RAS_pop & ~rollback;
  assign do_pop     = RAS_pop & ~RAS_push & ~rollback;
  assign do_replace = RAS_push & RAS_pop & ~rollback;
  // Paired ID rollbacks undo a replace: the overwritten entry comes back from bk.
  assign restore    = RAS_rollback_pop_id & RAS_rollback_push_id & bk_valid;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wp_next       = wp;
    cnt_next      = cnt;
    bk_valid_next = bk_valid;
    delta  = int'(RAS_rollback_push_id) + int'(RAS_rollback_push_ex)
           - int'(RAS_rollback_pop_id);
    cnt_rb = int'(cnt) + delta;
    if (cnt_rb < 0)     cnt_rb = 0;
    if (cnt_rb > DEPTH) cnt_rb = DEPTH;

    if (rollback) begin
      wp_next       = wp + PTR_W'(delta);
      cnt_next      = CNT_W'(cnt_rb);
      bk_valid_next = 1'b0;
    end else if (do_replace) begin
      bk_valid_next = 1'b1;
    end else if (do_push) begin
      wp_next       = wp + PTR_W'(1);
      cnt_next      = (cnt == CNT_W'(DEPTH)) ? cnt : cnt + CNT_W'(1);
      bk_valid_next = 1'b0;
    end else if (do_pop) begin
      bk_valid_next = 1'b0;
      if (cnt != '0) begin
        wp_next  = wp_m1;
        cnt_next = cnt - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      cnt      <= '0;
      bk_valid <= 1'b0;
      ra_track <= 5'd1;
    end else begin
      wp       <= wp_next;
      cnt      <= cnt_next;
      bk_valid <= bk_valid_next;
      if (WR_ra_track_en)
        ra_track <= WR_ra_track_data;
      else if (RAS_pop && !rollback)
        ra_track <= 5'd1;
    end
  end

  // NOTE: entry storage and bk are deliberately unreset; cnt/bk_valid qualify them.
  always_ff @(posedge clk) begin
    if (do_push)
      entry[wp] <= push_addr;
    else if (do_replace) begin
      entry[wp_m1] <= push_addr;
      bk           <= entry[wp_m1];
    end else if (restore)
      entry[wp_m1] <= bk;
  end

  assign RAS_top       = entry[wp_m1];
  assign RAS_top_valid = (cnt != '0);
  assign RAS_full      = (cnt == CNT_W'(DEPTH));
  assign RAS_ra_track  = ra_track;

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: stimulus queues expected state,
// a monitor compares it one clock edge later.
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RAS_push = 1'b0;
  logic [31:0] push_addr = '0;
  logic        RAS_pop = 1'b0;
  logic        RAS_rollback_pop_id = 1'b0;
  logic        RAS_rollback_push_id = 1'b0;
  logic        RAS_rollback_push_ex = 1'b0;
  logic        WR_ra_track_en = 1'b0;
  logic [4:0]  WR_ra_track_data = '0;
  logic [31:0] RAS_top;
  logic        RAS_top_valid;
  logic [4:0]  RAS_ra_track;
  logic        RAS_full;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic [31:0] top;
    logic        full;
    logic [4:0]  track;
    string       name;
  } exp_t;

  exp_t sb[$];

  return_address_stack #(.DEPTH(8), .ADDR_WIDTH(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .RAS_push            (RAS_push),
    .push_addr           (push_addr),
    .RAS_pop             (RAS_pop),
    .RAS_rollback_pop_id (RAS_rollback_pop_id),
    .RAS_rollback_push_id(RAS_rollback_push_id),
    .RAS_rollback_push_ex(RAS_rollback_push_ex),
    .WR_ra_track_en      (WR_ra_track_en),
    .WR_ra_track_data    (WR_ra_track_data),
    .RAS_top             (RAS_top),
    .RAS_top_valid       (RAS_top_valid),
    .RAS_ra_track        (RAS_ra_track),
    .RAS_full            (RAS_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // rb = {rollback_pop_id, rollback_push_id, rollback_push_ex}
  task automatic step(input logic push, input logic [31:0] addr, input logic pop,
                      input logic [2:0] rb, input logic ten, input logic [4:0] tdata,
                      input logic ev, input logic [31:0] et, input logic ef,
                      input logic [4:0] etr, input string nm);
    exp_t e;
    @(negedge clk);
    RAS_push             = push;
    push_addr            = addr;
    RAS_pop              = pop;
    RAS_rollback_pop_id  = rb[2];
    RAS_rollback_push_id = rb[1];
    RAS_rollback_push_ex = rb[0];
    WR_ra_track_en       = ten;
    WR_ra_track_data     = tdata;
    e.valid = ev; e.top = et; e.full = ef; e.track = etr; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: expected state becomes visible one edge after the command.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      check({e.name, ".valid"}, 32'(RAS_top_valid), 32'(e.valid));
      check({e.name, ".full"},  32'(RAS_full),      32'(e.full));
      check({e.name, ".track"}, 32'(RAS_ra_track),  32'(e.track));
      if (e.valid) check({e.name, ".top"}, RAS_top, e.top);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    vectors++;
    check("reset.valid", 32'(RAS_top_valid), 32'd0);
    check("reset.full",  32'(RAS_full),      32'd0);
    check("reset.track", 32'(RAS_ra_track),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic LIFO and pop-on-empty
    step(1, 32'h100, 0, 3'b000, 0, 0, 1, 32'h100, 0, 1, "push100");
    step(1, 32'h200, 0, 3'b000, 0, 0, 1, 32'h200, 0, 1, "push200");
    step(1, 32'h300, 0, 3'b000, 0, 0, 1, 32'h300, 0, 1, "push300");
    step(0, 0,       1, 3'b000, 0, 0, 1, 32'h200, 0, 1, "pop1");
    step(0, 0,       1, 3'b000, 0, 0, 1, 32'h100, 0, 1, "pop2");
    step(0, 0,       1, 3'b000, 0, 0, 0, 32'h0,   0, 1, "pop3");
    step(0, 0,       1, 3'b000, 0, 0, 0, 32'h0,   0, 1, "pop_empty");

    // Overflow: 9 pushes into 8 entries, oldest lost
    for (int i = 1; i <= 9; i++)
      step(1, 32'(i * 16), 0, 3'b000, 0, 0, 1, 32'(i * 16), (i >= 8), 1, "ovf_push");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 3'b000, 0, 0, (i < 8), 32'(32'h90 - i * 16), 0, 1, "ovf_pop");

    // Rollback of flushed pop and flushed push
    step(1, 32'hA0, 0, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "rb_pushA0");
    step(1, 32'hB0, 0, 3'b000, 0, 0, 1, 32'hB0, 0, 1, "rb_pushB0");
    step(0, 0,      1, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "rb_pop");
    step(0, 0,      0, 3'b001, 0, 0, 1, 32'hB0, 0, 1, "rb_push_ex");
    step(1, 32'hC0, 0, 3'b000, 0, 0, 1, 32'hC0, 0, 1, "rb_pushC0");
    step(0, 0,      0, 3'b100, 0, 0, 1, 32'hB0, 0, 1, "rb_pop_id");
    step(0, 0,      1, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "rb_cnt_pop1");
    step(0, 0,      1, 3'b000, 0, 0, 0, 32'h0,  0, 1, "rb_cnt_pop2");

    // Replace (push+pop) then paired ID rollback restores
    step(1, 32'hA0, 0, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "rep_pushA0");
    step(1, 32'hD0, 1, 3'b000, 0, 0, 1, 32'hD0, 0, 1, "rep_replace");
    step(0, 0,      0, 3'b110, 0, 0, 1, 32'hA0, 0, 1, "rep_restore");
    step(0, 0,      1, 3'b000, 0, 0, 0, 32'h0,  0, 1, "rep_cnt_pop");

    // Push ignored while rolling back
    step(1, 32'hA0, 0, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "ign_pushA0");
    step(1, 32'hB0, 0, 3'b000, 0, 0, 1, 32'hB0, 0, 1, "ign_pushB0");
    step(0, 0,      1, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "ign_pop");
    step(1, 32'hE0, 0, 3'b010, 0, 0, 1, 32'hB0, 0, 1, "ign_push_rb");
    step(0, 0,      1, 3'b000, 0, 0, 1, 32'hA0, 0, 1, "ign_pop1");
    step(0, 0,      1, 3'b000, 0, 0, 0, 32'h0,  0, 1, "ign_pop2");

    // ra-track register
    step(0, 0, 0, 3'b000, 1, 5'd5, 0, 0, 0, 5'd5, "trk_wr5");
    step(0, 0, 0, 3'b000, 1, 5'd0, 0, 0, 0, 5'd0, "trk_wr0");
    step(0, 0, 1, 3'b000, 0, 5'd0, 0, 0, 0, 5'd1, "trk_pop");
    step(0, 0, 1, 3'b000, 1, 5'd7, 0, 0, 0, 5'd7, "trk_pop_wr7");
    step(0, 0, 0, 3'b000, 0, 5'd0, 0, 0, 0, 5'd7, "trk_hold");
    step(0, 0, 0, 3'b100, 0, 5'd0, 0, 0, 0, 5'd7, "rb_pop_id_empty");
    step(1, 32'h55, 0, 3'b000, 0, 0, 1, 32'h55, 0, 5'd7, "push55");

    // Asynchronous reset mid-cycle, then reset winning over a pending push
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    check("async_rst.track", 32'(RAS_ra_track),  32'd1);
    check("async_rst.valid", 32'(RAS_top_valid), 32'd0);
    step(1, 32'h77, 0, 3'b000, 0, 0, 0, 32'h0, 0, 1, "rst_push_held");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 32'h66, 0, 3'b000, 0, 0, 1, 32'h66, 0, 1, "post_rst_push");
    step(0, 0,      1, 3'b000, 0, 0, 0, 32'h0,  0, 1, "post_rst_pop");
    step(0, 0,      0, 3'b000, 0, 0, 0, 32'h0,  0, 1, "idle");

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
